// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
// Shared definitions for the decode stage with hazard handling.
//   - Default datapath, register-address, zero-register and counter widths.
//   - Branch condition encoding (cond_e) and its flag decoder (cond_met).
// ---------------------------------------------------------------------------
package id_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_ZERO_REG = 31;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_HS = 4'b0010,
        COND_LO = 4'b0011,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110
    } cond_e;

    // Evaluates a condition code against the current NZCV flags.
    // Encodings that are not listed in cond_e never pass.
    function automatic logic cond_met(input logic [3:0] cond,
                                      input logic       n,
                                      input logic       z,
                                      input logic       c,
                                      input logic       v);
        logic met;
        met = 1'b0;
        case (cond)
            COND_EQ: met = z;
            COND_NE: met = ~z;
            COND_HS: met = c;
            COND_LO: met = ~c;
            COND_GE: met = (n == v);
            COND_LT: met = (n != v);
            COND_GT: met = ~z & (n == v);
            COND_LE: met = z | (n != v);
            COND_AL: met = 1'b1;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// ---------------------------------------------------------------------------
// regfile_bypass
// Two-read, one-write register array with a hardwired-zero register and a
// same-cycle write-back bypass on both read ports.
// Ports:
//   clk, rst               clock, asynchronous active-high reset (clears array)
//   wb_en/wb_addr/wb_data  write-back port, written at posedge clk
//   ra_addr/ra_data        read port A (combinational)
//   rb_addr/rb_data        read port B (combinational)
// ---------------------------------------------------------------------------
module regfile_bypass
    import id_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data
);

    localparam int                NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZR   = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != ZR)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // The zero register wins over the bypass so a write aimed at it can
    // never leak through in the same cycle.
    assign ra_data = (ra_addr == ZR)                  ? '0      :
                     (wb_en && (wb_addr == ra_addr))  ? wb_data :
                                                        regs_q[ra_addr];
    assign rb_data = (rb_addr == ZR)                  ? '0      :
                     (wb_en && (wb_addr == rb_addr))  ? wb_data :
                                                        regs_q[rb_addr];

endmodule

// File: rtl/id_stage_hz.sv
// ---------------------------------------------------------------------------
// id_stage_hz
// Instruction-decode stage: operand read with EX/MEM/WB forwarding, load-use
// stall detection, branch resolution and the ID/EX pipeline register.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   id_valid, pc, rn, ab, rd   decoded instruction in ID
//   ctl_*, cond, br_off        control bits, condition code, word offset
//   flag_n/z/c/v               current condition flags
//   ex_result                  ALU output of the instruction now in EX
//   flush                      squash the instruction entering EX
//   mem_fwd_*, wb_*            MEM forwarding source and write-back port
//   stall, br_taken, br_target hazard and branch outputs (combinational)
//   ex_*                       ID/EX register contents
//   stall_cnt                  saturating count of stall cycles
// ---------------------------------------------------------------------------
module id_stage_hz
    import id_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] pc,
    input  logic [ADDR_W-1:0] rn,
    input  logic [ADDR_W-1:0] ab,
    input  logic [ADDR_W-1:0] rd,
    input  logic              ctl_regwrite,
    input  logic              ctl_memread,
    input  logic              ctl_cbz,
    input  logic              ctl_uncond,
    input  logic              ctl_bcond,
    input  logic [3:0]        cond,
    input  logic [DATA_W-1:0] br_off,
    input  logic              flag_n,
    input  logic              flag_z,
    input  logic              flag_c,
    input  logic              flag_v,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              flush,
    input  logic              mem_fwd_en,
    input  logic [ADDR_W-1:0] mem_fwd_addr,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_da,
    output logic [DATA_W-1:0] ex_db,
    output logic [DATA_W-1:0] ex_pc,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    logic              ex_valid_q, ex_valid_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q, ex_memread_d;
    logic [DATA_W-1:0] ex_da_q, ex_db_q, ex_pc_q;
    logic [ADDR_W-1:0] ex_rd_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [DATA_W-1:0] rf_a, rf_b;
    logic [DATA_W-1:0] fwd_a, fwd_b;
    logic              ex_fwd_ok;
    logic              cond_ok;

    regfile_bypass #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rf (
        .clk     (clk),
        .rst     (reset),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .ra_addr (rn),
        .rb_addr (ab),
        .ra_data (rf_a),
        .rb_data (rf_b)
    );

    // A load in EX has no result yet, so only non-load writers forward from EX.
    assign ex_fwd_ok = ex_valid_q & ex_regwrite_q & ~ex_memread_q;

    // Operand selection: EX, then MEM; the WB bypass lives inside rf_a/rf_b.
    always_comb begin
        fwd_a = rf_a;
        if (rn == ZR) begin
            fwd_a = '0;
        end else if (ex_fwd_ok && (ex_rd_q == rn)) begin
            fwd_a = ex_result;
        end else if (mem_fwd_en && (mem_fwd_addr == rn)) begin
            fwd_a = mem_fwd_data;
        end
    end

    always_comb begin
        fwd_b = rf_b;
        if (ab == ZR) begin
            fwd_b = '0;
        end else if (ex_fwd_ok && (ex_rd_q == ab)) begin
            fwd_b = ex_result;
        end else if (mem_fwd_en && (mem_fwd_addr == ab)) begin
            fwd_b = mem_fwd_data;
        end
    end

    // Load-use hazard: the load in EX produces a source this instruction needs.
    assign stall = id_valid & ex_valid_q & ex_memread_q & (ex_rd_q != ZR) &
                   ((ex_rd_q == rn) | (ex_rd_q == ab));

    assign br_target = pc + (br_off << 2);
    assign cond_ok   = cond_met(cond, flag_n, flag_z, flag_c, flag_v);
    assign br_taken  = id_valid & ~stall &
                       (ctl_uncond | (ctl_cbz & (fwd_b == '0)) | (ctl_bcond & cond_ok));

    // Flush and stall both leave a bubble; the control bits are gated with
    // id_valid so an invalid slot never carries regwrite/memread.
    always_comb begin
        ex_valid_d    = id_valid;
        ex_regwrite_d = id_valid & ctl_regwrite;
        ex_memread_d  = id_valid & ctl_memread;
        if (flush || stall) begin
            ex_valid_d    = 1'b0;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
        end
    end

    // Stalls are counted even when a flush squashes the same slot.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_da_q       <= '0;
            ex_db_q       <= '0;
            ex_pc_q       <= '0;
            ex_rd_q       <= '0;
            stall_cnt_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_da_q       <= fwd_a;
            ex_db_q       <= fwd_b;
            ex_pc_q       <= pc;
            ex_rd_q       <= rd;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_memread  = ex_memread_q;
    assign ex_da       = ex_da_q;
    assign ex_db       = ex_db_q;
    assign ex_pc       = ex_pc_q;
    assign ex_rd       = ex_rd_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
